hazard_control_unit: RTL
========================

# hazard_control_unit

Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives the stall and flush inputs of the IF/ID pipeline register, plus PC write-enable and the ID/EX, EX/MEM bubble and freeze controls. Resolves three hazard sources each cycle: load-use data hazards, taken branches resolved in EX, and multi-cycle data-memory waits. Also keeps saturating hazard-event counters and a sticky memory-timeout error.

## Interface
- WAIT_TIMEOUT, 255: max consecutive dmem_busy cycles before the error trips; valid range 1..65535.
- CNT_WIDTH, 32: width of each performance counter.

- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- id_rs1, id_rs2  input  5 each  source register fields of the instruction in ID.
- id_uses_rs1, id_uses_rs2  input  1 each  the ID instruction actually reads rs1 / rs2.
- ex_mem_read  input  1  the instruction in EX is a load.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_branch_taken  input  1  branch in EX resolved taken this cycle.
- dmem_busy  input  1  data memory has not completed the MEM-stage access.
- pc_write  output  1  PC load enable.
- if_id_stall  output  1  hold the IF/ID register.
- if_id_flush  output  1  clear the IF/ID register.
- id_ex_flush  output  1  insert a bubble into ID/EX.
- pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- timeout_err  output  1  sticky memory-timeout flag.
- load_use_cnt, flush_cnt, stall_cycle_cnt  output  CNT_WIDTH each  hazard counters.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Hazard terms are evaluated combinationally from the current state and inputs (Mealy). Control takes effect in the same cycle the hazard is present.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority: ERROR > dmem_busy > ex_branch_taken > load_use.
- RUN, dmem_busy = 1:
  - pc_write = 0, if_id_stall = 1, pipe_freeze = 1, no flushes.
  - Next state MEM_WAIT; the wait counter loads 1.
- RUN, branch taken:
  - pc_write = 1 (target redirect), if_id_flush = 1, id_ex_flush = 1.
  - A simultaneous load_use is ignored, because its ID instruction is squashed.
- RUN, load_use only: pc_write = 0, if_id_stall = 1, id_ex_flush = 1.
- RUN, no hazard: pc_write = 1, all other controls 0.
- MEM_WAIT, dmem_busy = 1:
  - Outputs are identical to the RUN freeze case.
  - The wait counter increments, saturating at WAIT_TIMEOUT.
  - When the counter already equals WAIT_TIMEOUT and dmem_busy is still 1, the next state is ERROR.
- MEM_WAIT, dmem_busy = 0:
  - The freeze releases in this same cycle.
  - Outputs are computed exactly as in RUN, so a pending branch or load-use is handled in this cycle.
  - Next state RUN.
- ERROR:
  - pc_write = 0, if_id_stall = 1, pipe_freeze = 1, timeout_err = 1.
  - ERROR is left only by reset.
- Counters, all saturating at all-ones:
  - load_use_cnt increments on each cycle where load_use is the acted-on hazard.
  - flush_cnt increments on each acted-on branch flush.
  - stall_cycle_cnt increments on every cycle with pc_write = 0.
- if_id_stall and if_id_flush are never both 1 in the same cycle.

## Timing
- While reset_n = 0: all control outputs are 0 (pc_write included), counters are 0, timeout_err = 0, and the state is RUN. Asserting reset_n mid-MEM_WAIT or in ERROR aborts immediately, asynchronously.
- Deassertion of reset_n is synchronised externally. The first active edge follows RUN rules.
- Control latency is 0 cycles (combinational). State and counters have 1-cycle latency.
- A load-use hazard costs exactly 1 stall cycle. On the next cycle the load is in MEM and the hazard term drops.
- A taken branch costs 2 squashed instructions (IF/ID and ID/EX) in 1 cycle.
- A dmem wait of N busy cycles gives N freeze cycles.
- ERROR is entered on the edge ending busy cycle number WAIT_TIMEOUT+1.
- ex_rd = 0 never raises load_use.

## Test plan
- Load-use: lw x5 in EX (ex_mem_read=1, ex_rd=5), ID has id_rs2=5 with id_uses_rs2=1 -> exactly 1 cycle of pc_write=0, if_id_stall=1, id_ex_flush=1; load_use_cnt 0->1, stall_cycle_cnt 0->1.
- Branch over load-use: ex_branch_taken=1 with load_use true -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_stall=0; flush_cnt=1, load_use_cnt stays 0.
- Memory wait: dmem_busy high for 3 cycles with ex_branch_taken=1 held -> 3 cycles of pipe_freeze=1, pc_write=0. On the 4th cycle the flush fires and the state returns to RUN. stall_cycle_cnt=3.
- Timeout (WAIT_TIMEOUT=4): dmem_busy held high -> ERROR after the 5th busy edge; timeout_err=1 persists after dmem_busy drops. Pulsing reset_n low clears the error and all counters asynchronously.
- x0 and unused operands: ex_rd=0 with id_rs1=0, or id_uses_rs1=0 with id_rs1==ex_rd -> no stall; pc_write=1 and all other controls 0.
- Saturation (CNT_WIDTH=4): 20 consecutive load-use events -> load_use_cnt holds at 15.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_control_unit_if
//   Bundle between the pipeline datapath and the hazard control unit.
//   master : pipeline side, drives the hazard sources, receives controls.
//   slave  : hazard control unit, reads the hazard sources, drives controls.
//   Hazard sources : id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read,
//                    ex_rd, ex_branch_taken, dmem_busy
//   Controls       : pc_write, if_id_stall, if_id_flush, id_ex_flush,
//                    pipe_freeze, timeout_err
//   Counters       : load_use_cnt, flush_cnt, stall_cycle_cnt (CNT_WIDTH)
// ---------------------------------------------------------------------------
interface hazard_control_unit_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_uses_rs1;
  logic                 id_uses_rs2;
  logic                 ex_mem_read;
  logic [4:0]           ex_rd;
  logic                 ex_branch_taken;
  logic                 dmem_busy;

  logic                 pc_write;
  logic                 if_id_stall;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic                 pipe_freeze;
  logic                 timeout_err;
  logic [CNT_WIDTH-1:0] load_use_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic [CNT_WIDTH-1:0] stall_cycle_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd, ex_branch_taken, dmem_busy,
    input  pc_write, if_id_stall, if_id_flush, id_ex_flush,
           pipe_freeze, timeout_err,
           load_use_cnt, flush_cnt, stall_cycle_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd, ex_branch_taken, dmem_busy,
    output pc_write, if_id_stall, if_id_flush, id_ex_flush,
           pipe_freeze, timeout_err,
           load_use_cnt, flush_cnt, stall_cycle_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//   Central stall/flush sequencer for the 5-stage RV32 pipeline. Resolves
//   load-use hazards, taken branches in EX and multi-cycle dmem waits, and
//   keeps saturating hazard-event counters plus a sticky memory timeout.
//   Ports:
//     clk      : pipeline clock, rising edge
//     reset_n  : asynchronous active-low reset
//     hz       : hazard_control_unit_if.slave (sources in, controls out)
//   Parameters:
//     WAIT_TIMEOUT : max consecutive dmem_busy cycles (1..65535)
//     CNT_WIDTH    : width of each counter; must match the interface
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hazard_control_unit_if.slave  hz
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [WAIT_W-1:0]    w_wait_nxt;

  logic [CNT_WIDTH-1:0] r_load_use_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cycle_cnt;

  logic w_load_use;
  logic w_pc_write;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_pipe_freeze;
  logic w_timeout_err;
  logic w_act_load_use;
  logic w_act_flush;

  // ------------------------------------------------------------------------
  // Load-use detection: a load in EX whose (non-x0) destination is read by
  // the instruction currently in ID.
  // ------------------------------------------------------------------------
  assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // ------------------------------------------------------------------------
  // State register and memory-wait counter
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // ------------------------------------------------------------------------
  // Next state and Mealy control outputs.
  // Priority: ERROR > dmem_busy > branch taken > load-use. A MEM_WAIT cycle
  // that sees dmem_busy drop applies the RUN rules immediately, so a branch
  // or load-use held during the wait is resolved in the release cycle.
  // ------------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    w_wait_nxt     = r_wait_cnt;
    w_pc_write     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_pipe_freeze  = 1'b0;
    w_timeout_err  = 1'b0;
    w_act_load_use = 1'b0;
    w_act_flush    = 1'b0;

    unique case (r_state)
      S_ERROR: begin
        w_if_id_stall = 1'b1;
        w_pipe_freeze = 1'b1;
        w_timeout_err = 1'b1;
      end

      S_RUN, S_MEM_WAIT: begin
        if (hz.dmem_busy) begin
          w_if_id_stall = 1'b1;
          w_pipe_freeze = 1'b1;
          if (r_state == S_RUN) begin
            w_next_state = S_MEM_WAIT;
            w_wait_nxt   = WAIT_W'(1);
          end else if (r_wait_cnt == WAIT_LIMIT) begin
            // Busy cycle WAIT_TIMEOUT+1: give up on the memory.
            w_next_state = S_ERROR;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_next_state = S_RUN;
          w_wait_nxt   = '0;
          if (hz.ex_branch_taken) begin
            // The load-use victim in ID is squashed, so it is not counted.
            w_pc_write    = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_act_flush   = 1'b1;
          end else if (w_load_use) begin
            w_if_id_stall  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_act_load_use = 1'b1;
          end else begin
            w_pc_write = 1'b1;
          end
        end
      end

      default: begin
        w_next_state = S_RUN;
        w_wait_nxt   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Saturating hazard counters
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_use_cnt    <= '0;
      r_flush_cnt       <= '0;
      r_stall_cycle_cnt <= '0;
    end else begin
      if (w_act_load_use && (r_load_use_cnt != '1))
        r_load_use_cnt <= r_load_use_cnt + CNT_WIDTH'(1);
      if (w_act_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      if (!w_pc_write && (r_stall_cycle_cnt != '1))
        r_stall_cycle_cnt <= r_stall_cycle_cnt + CNT_WIDTH'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Outputs: controls are forced low for as long as reset is held, which
  // also covers a reset asserted mid-cycle.
  // ------------------------------------------------------------------------
  assign hz.pc_write        = reset_n & w_pc_write;
  assign hz.if_id_stall     = reset_n & w_if_id_stall;
  assign hz.if_id_flush     = reset_n & w_if_id_flush;
  assign hz.id_ex_flush     = reset_n & w_id_ex_flush;
  assign hz.pipe_freeze     = reset_n & w_pipe_freeze;
  assign hz.timeout_err     = reset_n & w_timeout_err;
  assign hz.load_use_cnt    = r_load_use_cnt;
  assign hz.flush_cnt       = r_flush_cnt;
  assign hz.stall_cycle_cnt = r_stall_cycle_cnt;

endmodule
